bram_dp_ext: RTL and testbench

- Parametrised true dual-port block RAM for the convolution accelerator. Successor to the basic dual-port BRAM.
- Adds the following over the basic BRAM:
  - per-byte write enables
  - selectable read latency (1 or 2 cycles) with read-valid strobes
  - defined read-during-write and write-collision rules
  - a hardware clear sequencer that zeroes the whole array
- Sits between the accelerator's DMA/loader and the MAC datapath as the feature-map and weight buffer.

---
 rtl/bram_ext_pkg.sv | 29 ++
 rtl/bram_rd_pipe.sv | 52 +++++
 rtl/bram_dp_ext.sv | 241 ++++++++++++++++++++++++
 tb/tb_bram_dp_ext.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_ext_pkg
// Description : Shared types and helpers for the extended dual-port BRAM.
//               Holds the read-during-write mode enum, the clear-sequencer
//               state enum and the address-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_ext_pkg;

    // Same-port read-during-write result selection
    typedef enum logic [0:0] {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } rdw_mode_e;

    // Clear sequencer states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    // Address width for a given depth; depth is always at least 2
    function automatic int calc_aw(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module      : bram_rd_pipe
// Description : Read data/valid output stage. With LATENCY=1 the first-stage
//               registers of the RAM drive the outputs directly; with
//               LATENCY=2 one extra aligned register stage is inserted.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_data/i_valid  - first-stage read data and read strobe
//               o_data/o_valid  - delayed read data and read strobe
// Revision    : 1.0 - initial release
// ============================================================================
module bram_rd_pipe #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    generate
        if (LATENCY >= 2) begin : g_lat2
            logic [WIDTH-1:0] r_data;
            logic             r_valid;

            // The input data already holds between reads, so sampling it
            // every cycle preserves the hold behaviour one cycle later.
            always_ff @(posedge clk) begin : p_stage
                if (rst) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_data  <= i_data;
                    r_valid <= i_valid;
                end
            end

            assign o_data  = r_data;
            assign o_valid = r_valid;
        end else begin : g_lat1
            logic w_unused;
            assign w_unused = clk ^ rst;
            assign o_data   = i_data;
            assign o_valid  = i_valid;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/bram_dp_ext.sv
`default_nettype none
// ============================================================================
// Module      : bram_dp_ext
// Description : True dual-port block RAM with per-byte write enables,
//               1- or 2-cycle read latency with valid strobes, defined
//               read-during-write / write-collision behaviour and a
//               hardware clear sequencer that zeroes the whole array.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               clear_req / clear_busy   - start pulse / sweep in progress
//               en_x, we_x, addr_x, din_x - port x access (we_x==0 is a read)
//               dout_x, valid_x          - port x read data / read strobe
//               collision                - both ports wrote overlapping bytes
//                                          of one address (one-cycle pulse)
// Revision    : 1.0 - initial release
// ============================================================================
module bram_dp_ext
    import bram_ext_pkg::*;
#(
    parameter int WORD_SIZE    = 32,
    parameter int RAM_DEPTH    = 256,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear_req,
    output logic                              clear_busy,
    input  logic                              en_a,
    input  logic [WORD_SIZE/8-1:0]            we_a,
    input  logic [calc_aw(RAM_DEPTH)-1:0]     addr_a,
    input  logic [WORD_SIZE-1:0]              din_a,
    output logic [WORD_SIZE-1:0]              dout_a,
    output logic                              valid_a,
    input  logic                              en_b,
    input  logic [WORD_SIZE/8-1:0]            we_b,
    input  logic [calc_aw(RAM_DEPTH)-1:0]     addr_b,
    input  logic [WORD_SIZE-1:0]              din_b,
    output logic [WORD_SIZE-1:0]              dout_b,
    output logic                              valid_b,
    output logic                              collision
);

    localparam int                c_AW   = calc_aw(RAM_DEPTH);
    localparam int                c_NB   = WORD_SIZE / 8;
    localparam rdw_mode_e         c_RDW  = (RDW_MODE == 1) ? WRITE_FIRST : READ_FIRST;
    localparam logic [c_AW-1:0]   c_LAST = c_AW'(RAM_DEPTH - 1);

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    clr_state_e       r_state;
    clr_state_e       w_state_nxt;
    logic [c_AW-1:0]  r_cnt;
    logic [c_AW-1:0]  w_cnt_nxt;
    logic             w_busy;

    always_ff @(posedge clk) begin : p_clr_reg
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin : p_clr_nxt
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (clear_req) begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                if (r_cnt == c_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_busy     = (r_state == CLEAR);
    assign clear_busy = w_busy;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    logic w_inr_a, w_inr_b;
    logic w_acc_a, w_acc_b;
    logic w_rd_a,  w_rd_b;
    logic w_wr_a,  w_wr_b;
    logic w_same_addr;

    generate
        if ((1 << c_AW) == RAM_DEPTH) begin : g_pow2
            assign w_inr_a = 1'b1;
            assign w_inr_b = 1'b1;
        end else begin : g_npow2
            assign w_inr_a = (int'(addr_a) < RAM_DEPTH);
            assign w_inr_b = (int'(addr_b) < RAM_DEPTH);
        end
    endgenerate

    // User ports are locked out for the whole sweep
    assign w_acc_a     = en_a & ~w_busy;
    assign w_acc_b     = en_b & ~w_busy;
    assign w_rd_a      = w_acc_a & ~(|we_a);
    assign w_rd_b      = w_acc_b & ~(|we_b);
    assign w_wr_a      = w_acc_a & (|we_a) & w_inr_a;
    assign w_wr_b      = w_acc_b & (|we_b) & w_inr_b;
    assign w_same_addr = (addr_a == addr_b);

    // ------------------------------------------------------------------
    // Storage: one byte-wide array per lane so each lane maps onto a
    // byte-write column of the block RAM. Port A wins overlapping bytes.
    // ------------------------------------------------------------------
    logic [WORD_SIZE-1:0] w_old_a, w_old_b;

    generate
        for (genvar gi = 0; gi < c_NB; gi++) begin : g_lane
            logic [7:0] r_lane [RAM_DEPTH];
            logic [7:0] r_rd_a;
            logic [7:0] r_rd_b;
            logic       w_lwr_a;
            logic       w_lwr_b;

            assign w_lwr_a = w_wr_a & we_a[gi];
            assign w_lwr_b = w_wr_b & we_b[gi] & ~(w_lwr_a & w_same_addr);

            always_ff @(posedge clk) begin : p_lane
                if (w_busy) begin
                    r_lane[r_cnt] <= 8'h00;
                end else begin
                    if (w_lwr_a) r_lane[addr_a] <= din_a[8*gi +: 8];
                    if (w_lwr_b) r_lane[addr_b] <= din_b[8*gi +: 8];
                end
                // Synchronous read of the pre-write contents
                if (w_acc_a) r_rd_a <= r_lane[addr_a];
                if (w_acc_b) r_rd_b <= r_lane[addr_b];
            end

            assign w_old_a[8*gi +: 8] = r_rd_a;
            assign w_old_b[8*gi +: 8] = r_rd_b;
        end
    endgenerate

    // ------------------------------------------------------------------
    // First read stage: side information captured alongside the RAM read
    // register. r_zero forces the output to zero after reset and for
    // out-of-range accesses; r_wbe is non-zero only for a same-port
    // write in WRITE_FIRST mode and merges the new bytes over the old word.
    // ------------------------------------------------------------------
    logic                 r_zero_a, r_zero_b;
    logic                 r_rdv_a,  r_rdv_b;
    logic [c_NB-1:0]      r_wbe_a,  r_wbe_b;
    logic [WORD_SIZE-1:0] r_wd_a,   r_wd_b;
    logic                 r_coll;

    always_ff @(posedge clk) begin : p_stage0
        if (rst) begin
            r_zero_a <= 1'b1;
            r_zero_b <= 1'b1;
            r_rdv_a  <= 1'b0;
            r_rdv_b  <= 1'b0;
            r_wbe_a  <= '0;
            r_wbe_b  <= '0;
            r_wd_a   <= '0;
            r_wd_b   <= '0;
            r_coll   <= 1'b0;
        end else begin
            r_rdv_a <= w_rd_a;
            r_rdv_b <= w_rd_b;
            if (w_acc_a) begin
                r_zero_a <= ~w_inr_a;
                r_wbe_a  <= (c_RDW == WRITE_FIRST) ? we_a : '0;
                r_wd_a   <= din_a;
            end
            if (w_acc_b) begin
                r_zero_b <= ~w_inr_b;
                r_wbe_b  <= (c_RDW == WRITE_FIRST) ? we_b : '0;
                r_wd_b   <= din_b;
            end
            r_coll <= w_wr_a & w_wr_b & w_same_addr & (|(we_a & we_b));
        end
    end

    logic [WORD_SIZE-1:0] w_mask_a, w_mask_b;
    logic [WORD_SIZE-1:0] w_s0_a,   w_s0_b;

    always_comb begin : p_merge
        w_mask_a = '0;
        w_mask_b = '0;
        for (int i = 0; i < c_NB; i++) begin
            w_mask_a[8*i +: 8] = {8{r_wbe_a[i]}};
            w_mask_b[8*i +: 8] = {8{r_wbe_b[i]}};
        end
        w_s0_a = r_zero_a ? '0 : ((w_old_a & ~w_mask_a) | (r_wd_a & w_mask_a));
        w_s0_b = r_zero_b ? '0 : ((w_old_b & ~w_mask_b) | (r_wd_b & w_mask_b));
    end

    assign collision = r_coll;

    // ------------------------------------------------------------------
    // Output latency stages
    // ------------------------------------------------------------------
    bram_rd_pipe #(
        .WIDTH   (WORD_SIZE),
        .LATENCY (READ_LATENCY)
    ) u_pipe_a (
        .clk     (clk),
        .rst     (rst),
        .i_data  (w_s0_a),
        .i_valid (r_rdv_a),
        .o_data  (dout_a),
        .o_valid (valid_a)
    );

    bram_rd_pipe #(
        .WIDTH   (WORD_SIZE),
        .LATENCY (READ_LATENCY)
    ) u_pipe_b (
        .clk     (clk),
        .rst     (rst),
        .i_data  (w_s0_b),
        .i_valid (r_rdv_b),
        .o_data  (dout_b),
        .o_valid (valid_b)
    );

endmodule
`default_nettype wire

// File: tb/tb_bram_dp_ext.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_dp_ext
// Description : Directed self-checking bench. Two instances share stimulus:
//               dut1 = 256 words, latency 1, READ_FIRST
//               dut2 = 20 words (non power of two), latency 2, WRITE_FIRST
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_dp_ext;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear_req = 1'b0;
    logic        en_a = 1'b0, en_b = 1'b0;
    logic [3:0]  we_a = '0, we_b = '0;
    logic [7:0]  addr_a = '0, addr_b = '0;
    logic [31:0] din_a = '0, din_b = '0;

    logic [31:0] dout_a1, dout_b1, dout_a2, dout_b2;
    logic        valid_a1, valid_b1, valid_a2, valid_b2;
    logic        coll1, coll2, busy1, busy2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bram_dp_ext #(.WORD_SIZE(32), .RAM_DEPTH(256), .READ_LATENCY(1), .RDW_MODE(0)) dut1 (
        .clk(clk), .rst(rst), .clear_req(clear_req), .clear_busy(busy1),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
        .dout_a(dout_a1), .valid_a(valid_a1),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
        .dout_b(dout_b1), .valid_b(valid_b1), .collision(coll1)
    );

    bram_dp_ext #(.WORD_SIZE(32), .RAM_DEPTH(20), .READ_LATENCY(2), .RDW_MODE(1)) dut2 (
        .clk(clk), .rst(rst), .clear_req(clear_req), .clear_busy(busy2),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a[4:0]), .din_a(din_a),
        .dout_a(dout_a2), .valid_a(valid_a2),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b[4:0]), .din_b(din_b),
        .dout_b(dout_b2), .valid_b(valid_b2), .collision(coll2)
    );

    // Inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en_a = 1'b0; we_a = '0; en_b = 1'b0; we_b = '0; clear_req = 1'b0;
    endtask

    task automatic wr_a(input logic [7:0] a, input logic [31:0] d, input logic [3:0] w);
        en_a = 1'b1; we_a = w; addr_a = a; din_a = d;
        tick();
        idle();
    endtask

    task automatic wr_b(input logic [7:0] a, input logic [31:0] d, input logic [3:0] w);
        en_b = 1'b1; we_b = w; addr_b = a; din_b = d;
        tick();
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        tick(); tick();
        checks++;
        if ({valid_a1, valid_b1, valid_a2, valid_b2, coll1, coll2, busy1, busy2} !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags: got %b required 00000000",
                     {valid_a1, valid_b1, valid_a2, valid_b2, coll1, coll2, busy1, busy2});
        end
        checks++;
        if ({dout_a1, dout_b1, dout_a2, dout_b2} !== 128'h0) begin
            errors++;
            $display("FAIL reset_dout: got %h %h %h %h required 0", dout_a1, dout_b1, dout_a2, dout_b2);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_byte_enable();
        wr_a(8'd5, 32'h11223344, 4'b1111);
        wr_a(8'd5, 32'hAABBCCDD, 4'b0101);
        en_a = 1'b1; we_a = '0; addr_a = 8'd5;
        tick(); idle();
        checks++;
        if ({valid_a1, dout_a1, valid_a2} !== {1'b1, 32'h11BB33DD, 1'b0}) begin
            errors++;
            $display("FAIL be_lat1: got v1=%b d1=%h v2=%b required v1=1 d1=11bb33dd v2=0",
                     valid_a1, dout_a1, valid_a2);
        end
        tick();
        checks++;
        if ({valid_a2, dout_a2, valid_a1, dout_a1} !== {1'b1, 32'h11BB33DD, 1'b0, 32'h11BB33DD}) begin
            errors++;
            $display("FAIL be_lat2: got v2=%b d2=%h v1=%b d1=%h required 1 11bb33dd 0 11bb33dd",
                     valid_a2, dout_a2, valid_a1, dout_a1);
        end
        tick();
        checks++;
        if ({valid_a2, dout_a2} !== {1'b0, 32'h11BB33DD}) begin
            errors++;
            $display("FAIL be_hold2: got v2=%b d2=%h required 0 11bb33dd", valid_a2, dout_a2);
        end
    endtask

    task automatic test_latency();
        for (int i = 0; i < 4; i++) wr_b(8'(i), 32'h10 + 32'(i), 4'b1111);
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                en_a = 1'b1; we_a = '0; addr_a = 8'(c);
            end else begin
                idle();
            end
            tick();
            checks++;
            if (valid_a1 !== (c < 4) || (c < 4 && dout_a1 !== 32'h10 + 32'(c))) begin
                errors++;
                $display("FAIL lat_dut1 c=%0d: got v=%b d=%h required v=%b d=%h",
                         c, valid_a1, dout_a1, (c < 4), 32'h10 + 32'(c));
            end
            checks++;
            if (valid_a2 !== (c >= 1 && c <= 4) || (c >= 1 && c <= 4 && dout_a2 !== 32'h10 + 32'(c - 1))) begin
                errors++;
                $display("FAIL lat_dut2 c=%0d: got v=%b d=%h required v=%b d=%h",
                         c, valid_a2, dout_a2, (c >= 1 && c <= 4), 32'h10 + 32'(c - 1));
            end
        end
    endtask

    task automatic test_rdw();
        wr_a(8'd7, 32'h1, 4'b1111);
        // Port A writes addr 7 while port B reads it in the same cycle
        en_a = 1'b1; we_a = 4'b1111; addr_a = 8'd7; din_a = 32'h2;
        en_b = 1'b1; we_b = 4'b0000; addr_b = 8'd7;
        tick(); idle();
        checks++;
        if ({valid_a1, dout_a1, valid_b1, dout_b1} !== {1'b0, 32'h1, 1'b1, 32'h1}) begin
            errors++;
            $display("FAIL rdw_read_first: got va=%b da=%h vb=%b db=%h required 0 1 1 1",
                     valid_a1, dout_a1, valid_b1, dout_b1);
        end
        tick();
        checks++;
        if ({valid_a2, dout_a2, valid_b2, dout_b2} !== {1'b0, 32'h2, 1'b1, 32'h1}) begin
            errors++;
            $display("FAIL rdw_write_first: got va=%b da=%h vb=%b db=%h required 0 2 1 1",
                     valid_a2, dout_a2, valid_b2, dout_b2);
        end
        en_b = 1'b1; we_b = '0; addr_b = 8'd7;
        tick(); idle();
        tick();
        checks++;
        if ({dout_b1, dout_b2} !== {32'h2, 32'h2}) begin
            errors++;
            $display("FAIL rdw_mem: got %h %h required 2 2", dout_b1, dout_b2);
        end
    endtask

    task automatic test_collision();
        wr_a(8'd9, 32'h0, 4'b1111);
        en_a = 1'b1; we_a = 4'b1100; addr_a = 8'd9; din_a = 32'hAAAAAAAA;
        en_b = 1'b1; we_b = 4'b0110; addr_b = 8'd9; din_b = 32'hBBBBBBBB;
        tick(); idle();
        checks++;
        if ({coll1, coll2} !== 2'b11) begin
            errors++;
            $display("FAIL coll_pulse: got %b required 11", {coll1, coll2});
        end
        tick();
        checks++;
        if ({coll1, coll2} !== 2'b00) begin
            errors++;
            $display("FAIL coll_single: got %b required 00", {coll1, coll2});
        end
        // Disjoint byte lanes on one address: both land, no collision
        en_a = 1'b1; we_a = 4'b0011; addr_a = 8'd10; din_a = 32'h11112222;
        en_b = 1'b1; we_b = 4'b1100; addr_b = 8'd10; din_b = 32'h33334444;
        tick(); idle();
        checks++;
        if ({coll1, coll2} !== 2'b00) begin
            errors++;
            $display("FAIL coll_disjoint: got %b required 00", {coll1, coll2});
        end
        en_a = 1'b1; we_a = '0; addr_a = 8'd9;
        en_b = 1'b1; we_b = '0; addr_b = 8'd10;
        tick(); idle();
        tick();
        checks++;
        if ({dout_a1, dout_a2, dout_b1, dout_b2} !== {32'hAAAABB00, 32'hAAAABB00, 32'h33332222, 32'h33332222}) begin
            errors++;
            $display("FAIL coll_mem: got %h %h %h %h required aaaabb00 aaaabb00 33332222 33332222",
                     dout_a1, dout_a2, dout_b1, dout_b2);
        end
    endtask

    task automatic test_out_of_range();
        wr_a(8'd25, 32'hDEADBEEF, 4'b1111);
        en_a = 1'b1; we_a = '0; addr_a = 8'd5;
        tick();
        addr_a = 8'd25;
        tick(); idle();
        checks++;
        if ({valid_a1, dout_a1, valid_a2, dout_a2} !== {1'b1, 32'hDEADBEEF, 1'b1, 32'h11BB33DD}) begin
            errors++;
            $display("FAIL oor_seq: got v1=%b d1=%h v2=%b d2=%h required 1 deadbeef 1 11bb33dd",
                     valid_a1, dout_a1, valid_a2, dout_a2);
        end
        tick();
        checks++;
        if ({valid_a2, dout_a2} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL oor_read: got v2=%b d2=%h required 1 0", valid_a2, dout_a2);
        end
    endtask

    task automatic test_clear();
        int n1 = 0, n2 = 0, vbad = 0, bad1 = 0, bad2 = 0;
        for (int a = 0; a < 256; a++) begin
            en_a = 1'b1; we_a = 4'b1111; addr_a = 8'(a); din_a = 32'(a) + 32'h1;
            tick();
        end
        idle();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (busy1) n1++;
            if (busy2) n2++;
            if (valid_a1 | valid_b1 | valid_a2 | valid_b2) vbad++;
            en_a = (i == 5); we_a = '0; addr_a = 8'd3;
            en_b = (i == 5); we_b = (i == 5) ? 4'b1111 : 4'b0000; addr_b = 8'd2; din_b = 32'h55;
            clear_req = (i == 8);
            tick();
        end
        idle();
        checks++;
        if (n1 !== 256 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL clr_busy1: got %0d cycles (end=%b) required 256 (end=0)", n1, busy1);
        end
        checks++;
        if (n2 !== 20 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL clr_busy2: got %0d cycles (end=%b) required 20 (end=0)", n2, busy2);
        end
        checks++;
        if (vbad !== 0) begin
            errors++;
            $display("FAIL clr_no_valid: got %0d valid cycles required 0", vbad);
        end
        for (int c = 0; c < 257; c++) begin
            if (c < 256) begin
                en_a = 1'b1; we_a = '0; addr_a = 8'(c);
            end else begin
                idle();
            end
            tick();
            if (c < 256 && (valid_a1 !== 1'b1 || dout_a1 !== 32'h0)) bad1++;
            if (c >= 1 && (valid_a2 !== 1'b1 || dout_a2 !== 32'h0)) bad2++;
        end
        checks++;
        if (bad1 !== 0) begin
            errors++;
            $display("FAIL clr_zero1: got %0d bad words required 0", bad1);
        end
        checks++;
        if (bad2 !== 0) begin
            errors++;
            $display("FAIL clr_zero2: got %0d bad words required 0", bad2);
        end
    endtask

    task automatic test_reset_mid_sweep();
        wr_a(8'd5, 32'h12345678, 4'b1111);
        en_a = 1'b1; we_a = '0; addr_a = 8'd5; clear_req = 1'b1;
        tick(); idle();
        checks++;
        if ({valid_a1, dout_a1, busy1, busy2} !== {1'b1, 32'h12345678, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL mid_start: got v1=%b d1=%h b1=%b b2=%b required 1 12345678 1 1",
                     valid_a1, dout_a1, busy1, busy2);
        end
        tick();
        checks++;
        if ({valid_a2, dout_a2} !== {1'b1, 32'h12345678}) begin
            errors++;
            $display("FAIL mid_pipe_drain: got v2=%b d2=%h required 1 12345678", valid_a2, dout_a2);
        end
        for (int i = 2; i <= 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy1, busy2, valid_a1, valid_b1, valid_a2, valid_b2, coll1, coll2} !== 8'h00 ||
            {dout_a1, dout_b1, dout_a2, dout_b2} !== 128'h0) begin
            errors++;
            $display("FAIL mid_reset: got flags=%b dout=%h %h %h %h required all 0",
                     {busy1, busy2, valid_a1, valid_b1, valid_a2, valid_b2, coll1, coll2},
                     dout_a1, dout_b1, dout_a2, dout_b2);
        end
        clear_req = 1'b1;
        tick(); idle();
        checks++;
        if ({busy1, busy2} !== 2'b11) begin
            errors++;
            $display("FAIL mid_restart: got %b required 11", {busy1, busy2});
        end
        for (int k = 0; k < 400 && (busy1 || busy2); k++) tick();
        checks++;
        if ({busy1, busy2} !== 2'b00) begin
            errors++;
            $display("FAIL mid_finish: sweep still busy %b required 00", {busy1, busy2});
        end
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_latency();
        test_rdw();
        test_collision();
        test_out_of_range();
        test_clear();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
